// File: rtl/layer_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper for the
// reverse-direction (back-propagation) layer.
package layer_pkg;

   localparam int W    = 16;
   localparam int FRAC = 12;
   localparam logic signed [W:0] ONE = (W+1)'(1 << FRAC);

   typedef enum logic [1:0] {
      IDLE,
      DERIV,
      ACCUM,
      DONE
   } state_e;

   // Clamp a wide signed value into the W-bit two's-complement range.
   function automatic logic signed [W-1:0] sat16(input logic signed [63:0] acc);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (W - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (W - 1));
      if (acc > hi) begin
         sat16 = {1'b0, {(W-1){1'b1}}};
      end else if (acc < lo) begin
         sat16 = {1'b1, {(W-1){1'b0}}};
      end else begin
         sat16 = acc[W-1:0];
      end
   endfunction

endpackage

// File: rtl/layer_backprop_mac.sv
// Shared fixed-point multiply-accumulate: acc = (clr ? 0 : acc) + (en ? (a*b)>>>FRAC : 0).
// The output is the accumulator value including this cycle's term.
module fixed_mac
   import layer_pkg::*;
#(
   parameter int A_W   = W,
   parameter int B_W   = 2*W + 1,
   parameter int ACC_W = 2*W + 6
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      prod  = P_W'(a) * P_W'(b);
      term  = ACC_W'(prod >>> FRAC);
      base  = clr ? '0 : acc_q;
      acc_d = en ? base + term : base;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_d;

endmodule

// File: rtl/layer_backprop.sv
// Back-propagation companion of the forward MAC/sigmoid layer: local gradients
// delta[j] = e*y*(1-y), then deltaIn[i] = sum_j w[j*N_IN+i]*delta[j] on one shared MAC.
module layer_backprop
   import layer_pkg::*;
#(
   parameter int N_IN  = 12,
   parameter int N_OUT = 64
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                run,
   input  logic [N_OUT-1:0][W-1:0]             errIn,
   input  logic [N_OUT-1:0][W-1:0]             actOut,
   output logic [$clog2(N_IN*N_OUT)-1:0]       w_addr,
   input  logic [W-1:0]                        w_data,
   output logic [N_IN-1:0][W-1:0]              deltaIn,
   output logic [N_OUT-1:0][W-1:0]             delta,
   output logic                                busy,
   output logic                                done
);

   localparam int ADDR_W = $clog2(N_IN * N_OUT);
   localparam int I_W    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int K_W    = $clog2(N_OUT + 1);
   localparam int G_W    = 2*W + 1;
   localparam int ACC_W  = 2*W + $clog2(N_OUT);

   localparam logic [J_W-1:0]    J_LAST    = J_W'(N_OUT - 1);
   localparam logic [K_W-1:0]    K_LAST    = K_W'(N_OUT);
   localparam logic [K_W-1:0]    K_ADDR_END = K_W'(N_OUT - 1);
   localparam logic [I_W-1:0]    I_LAST    = I_W'(N_IN - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(N_IN);

   state_e                    state_q, state_d;
   logic [J_W-1:0]            j_q, j_d;
   logic [K_W-1:0]            k_q, k_d;
   logic [I_W-1:0]            i_q, i_d;
   logic [ADDR_W-1:0]         w_addr_q, w_addr_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [N_OUT-1:0][W-1:0]   delta_out_q, delta_out_d;
   logic [N_IN-1:0][W-1:0]    delta_in_q, delta_in_d;

   // Working copies: inputs captured at accept, gradients and partial results
   // built up before being published together on DONE.
   logic [N_OUT-1:0][W-1:0]   err_q, err_d;
   logic [N_OUT-1:0][W-1:0]   act_q, act_d;
   logic [N_OUT-1:0][W-1:0]   grad_q, grad_d;
   logic [N_IN-1:0][W-1:0]    back_q, back_d;

   logic signed [W-1:0]       y;
   logic signed [W:0]         omy;
   logic signed [G_W-1:0]     gprod;
   logic signed [G_W-1:0]     g;
   logic [J_W-1:0]            k_prev;

   logic                      mac_clr;
   logic                      mac_en;
   logic signed [W-1:0]       mac_a;
   logic signed [G_W-1:0]     mac_b;
   logic signed [ACC_W-1:0]   mac_acc;

   fixed_mac #(
      .A_W   (W),
      .B_W   (G_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (mac_clr),
      .en      (mac_en),
      .a       (mac_a),
      .b       (mac_b),
      .acc     (mac_acc)
   );

   always_comb begin
      state_d     = state_q;
      j_d         = j_q;
      k_d         = k_q;
      i_d         = i_q;
      w_addr_d    = w_addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      delta_out_d = delta_out_q;
      delta_in_d  = delta_in_q;
      err_d       = err_q;
      act_d       = act_q;
      grad_d      = grad_q;
      back_d      = back_q;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;
      mac_a       = '0;
      mac_b       = '0;

      // 1-y is formed one bit wider so activations outside [0,1] do not wrap.
      y      = signed'(act_q[j_q]);
      omy    = ONE - (W+1)'(y);
      gprod  = G_W'(y) * G_W'(omy);
      g      = gprod >>> FRAC;
      k_prev = J_W'(k_q - 1'b1);

      case (state_q)
         IDLE: begin
            if (busy_q) begin
               // Done-pulse cycle: busy drops now and a run here is ignored.
               busy_d = 1'b0;
            end else if (run) begin
               err_d   = errIn;
               act_d   = actOut;
               j_d     = '0;
               busy_d  = 1'b1;
               state_d = DERIV;
            end
         end

         DERIV: begin
            mac_clr     = 1'b1;
            mac_en      = 1'b1;
            mac_a       = signed'(err_q[j_q]);
            mac_b       = g;
            grad_d[j_q] = sat16(64'(mac_acc));
            if (j_q == J_LAST) begin
               state_d  = ACCUM;
               k_d      = '0;
               i_d      = '0;
               w_addr_d = '0;
            end else begin
               j_d = j_q + 1'b1;
            end
         end

         ACCUM: begin
            // Weight read issued in cycle k arrives in cycle k+1, pairing with delta[k].
            mac_clr = (k_q == '0);
            mac_en  = (k_q != '0);
            mac_a   = signed'(grad_q[k_prev]);
            mac_b   = G_W'(signed'(w_data));
            if (k_q == K_LAST) begin
               back_d[i_q] = sat16(64'(mac_acc));
               k_d         = '0;
               if (i_q == I_LAST) begin
                  state_d = DONE;
               end else begin
                  i_d      = i_q + 1'b1;
                  w_addr_d = ADDR_W'(i_q) + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
               if (k_q < K_ADDR_END) begin
                  w_addr_d = w_addr_q + ADDR_STEP;
               end
            end
         end

         DONE: begin
            delta_in_d  = back_q;
            delta_out_d = grad_q;
            done_d      = 1'b1;
            state_d     = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         j_q         <= '0;
         k_q         <= '0;
         i_q         <= '0;
         w_addr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         delta_out_q <= '0;
         delta_in_q  <= '0;
      end else begin
         state_q     <= state_d;
         j_q         <= j_d;
         k_q         <= k_d;
         i_q         <= i_d;
         w_addr_q    <= w_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         delta_out_q <= delta_out_d;
         delta_in_q  <= delta_in_d;
      end
   end

   // NOTE: working arrays are left out of reset; they are always written before being read.
   always_ff @(posedge clk) begin
      err_q  <= err_d;
      act_q  <= act_d;
      grad_q <= grad_d;
      back_q <= back_d;
   end

   assign w_addr  = w_addr_q;
   assign deltaIn = delta_in_q;
   assign delta   = delta_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_layer_backprop.sv
// Directed self-checking bench for layer_backprop with hand-computed expectations
// and a 1-cycle-latency weight memory model.
module tb_layer_backprop;
   import layer_pkg::*;

   localparam int N_IN   = 12;
   localparam int N_OUT  = 64;
   localparam int ADDR_W = 10;

   typedef logic [N_OUT-1:0][W-1:0] vec_out_t;
   typedef logic [N_IN-1:0][W-1:0]  vec_in_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              run;
   vec_out_t          errIn;
   vec_out_t          actOut;
   logic [ADDR_W-1:0] w_addr;
   logic [W-1:0]      w_data;
   vec_in_t           deltaIn;
   vec_out_t          delta;
   logic              busy;
   logic              done;

   logic [W-1:0] wmem [1024];

   int n_tests = 0;
   int n_fail  = 0;

   layer_backprop #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run),
      .errIn   (errIn),
      .actOut  (actOut),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .deltaIn (deltaIn),
      .delta   (delta),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) w_data <= wmem[w_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_uniform(input logic [W-1:0] y, input logic [W-1:0] e, input logic [W-1:0] w);
      for (int j = 0; j < N_OUT; j++) begin
         actOut[j] = y;
         errIn[j]  = e;
      end
      for (int a = 0; a < 1024; a++) wmem[a] = w;
   endtask

   task automatic verify(input string name, input vec_out_t d_got, input vec_out_t d_exp,
                         input vec_in_t i_got, input vec_in_t i_exp);
      for (int j = 0; j < N_OUT; j++)
         check($sformatf("%s delta[%0d]", name, j), 32'(d_got[j]), 32'(d_exp[j]));
      for (int i = 0; i < N_IN; i++)
         check($sformatf("%s deltaIn[%0d]", name, i), 32'(i_got[i]), 32'(i_exp[i]));
   endtask

   // Starts one operation and watches a fixed window of cycles after the accept edge.
   task automatic run_op(input bit pulse_busy, input bit chk_addr,
                         output vec_in_t din_snap, output vec_out_t d_snap);
      int done_at;
      int dones;
      int c;
      int ii;
      int kk;
      done_at  = -1;
      dones    = 0;
      din_snap = '0;
      d_snap   = '0;
      @(negedge clk);
      run = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b0;
      check("busy_on_accept", 32'(busy), 32'd1);
      check("done_low_on_accept", 32'(done), 32'd0);
      for (int n = 1; n <= 880; n++) begin
         @(posedge clk);
         #1;
         run = (pulse_busy && (n == 400 || n == 845)) ? 1'b1 : 1'b0;
         if (chk_addr && n >= 64 && n <= 843) begin
            c  = n - 64;
            ii = c / 65;
            kk = c % 65;
            if (kk < 64)
               check($sformatf("w_addr i=%0d k=%0d", ii, kk), 32'(w_addr), 32'(kk * 12 + ii));
         end
         if (done) begin
            dones++;
            if (done_at < 0) begin
               done_at  = n;
               din_snap = deltaIn;
               d_snap   = delta;
               check("busy_in_done_cycle", 32'(busy), 32'd1);
            end
         end
         if (done_at >= 0 && n == done_at + 1) begin
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_clear_after_done", 32'(busy), 32'd0);
         end
      end
      run = 1'b0;
      check("done_latency", 32'(done_at), 32'd845);
      check("done_count", 32'(dones), 32'd1);
   endtask

   initial begin
      vec_in_t  din;
      vec_out_t dv;
      vec_in_t  exp_i;
      vec_out_t exp_d;

      run     = 1'b0;
      reset_n = 1'b1;
      errIn   = '0;
      actOut  = '0;
      for (int a = 0; a < 1024; a++) wmem[a] = '0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset w_addr", 32'(w_addr), 32'd0);
      verify("reset", delta, '0, deltaIn, '0);
      reset_n = 1'b1;
      @(negedge clk);

      // Mid-scale activation, unit error, small weights.
      set_uniform(16'h0800, 16'h1000, 16'h0100);
      run_op(1'b0, 1'b0, din, dv);
      verify("t2", dv, {N_OUT{16'h0400}}, din, {N_IN{16'h1000}});

      // Reset in the middle of ACCUM clears everything.
      set_uniform(16'h0800, 16'h1000, 16'h1000);
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (200) @(negedge clk);
      check("busy_before_mid_reset", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_reset busy", 32'(busy), 32'd0);
      check("mid_reset done", 32'(done), 32'd0);
      check("mid_reset w_addr", 32'(w_addr), 32'd0);
      verify("mid_reset", delta, '0, deltaIn, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", 32'(busy), 32'd0);

      // Unit weights: the sum reaches 16.0 and saturates.
      run_op(1'b0, 1'b0, din, dv);
      verify("t3", dv, {N_OUT{16'h0400}}, din, {N_IN{16'h7FFF}});

      // Negative error.
      set_uniform(16'h0800, 16'hF000, 16'h0100);
      run_op(1'b0, 1'b0, din, dv);
      verify("t4", dv, {N_OUT{16'hFC00}}, din, {N_IN{16'hF000}});

      // Activations at 0 or 1 kill the gradient regardless of error and weights.
      for (int j = 0; j < N_OUT; j++) begin
         actOut[j] = j[0] ? 16'h1000 : 16'h0000;
         errIn[j]  = 16'($urandom);
      end
      for (int a = 0; a < 1024; a++) wmem[a] = 16'($urandom);
      run_op(1'b0, 1'b0, din, dv);
      verify("t5", dv, '0, din, '0);

      // One-hot gradient with address-valued weights; run pulses while busy are ignored.
      set_uniform(16'h0800, 16'h0000, 16'h0000);
      errIn[5] = 16'h1000;
      for (int a = 0; a < 1024; a++) wmem[a] = 16'(a);
      exp_d    = '0;
      exp_d[5] = 16'h0400;
      for (int i = 0; i < N_IN; i++) exp_i[i] = 16'(((5 * 12 + i) * 32'h400) >>> 12);
      run_op(1'b1, 1'b1, din, dv);
      verify("t6", dv, exp_d, din, exp_i);

      // Out-of-range activations, floor rounding of a tiny negative, negative saturation.
      for (int j = 0; j < N_OUT; j++) begin
         case (j % 3)
            0: begin actOut[j] = 16'h2000; errIn[j] = 16'h1000; exp_d[j] = 16'hE000; end
            1: begin actOut[j] = 16'h8000; errIn[j] = 16'h1000; exp_d[j] = 16'h8000; end
            default: begin actOut[j] = 16'h0800; errIn[j] = 16'hFFFF; exp_d[j] = 16'hFFFF; end
         endcase
      end
      for (int a = 0; a < 1024; a++) wmem[a] = 16'h0100;
      run_op(1'b0, 1'b0, din, dv);
      verify("t7", dv, exp_d, din, {N_IN{16'h8000}});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
